// File: rtl/regfile_scoreboard.sv
// Register file with two prioritised write ports, optional zero register and
// write bypass, plus a per-register pending bit used for RAW hazard detection.
module regfile_scoreboard #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs0_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [WIDTH-1:0]  rs0_data,
    output logic [WIDTH-1:0]  rs1_data,
    output logic              rs0_busy,
    output logic              rs1_busy,
    input  logic              wa_en,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic [WIDTH-1:0]  wa_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data,
    output logic [ADDR_W:0]   pending_cnt,
    output logic              wr_conflict
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              conflict_q, conflict_d;

    logic              wa_act, wb_act, is_act;
    logic              set_bit, clr_a, clr_b;

    logic [ADDR_W-1:0] rs_addr [2];
    logic [WIDTH-1:0]  rs_data [2];
    logic              rs_busy [2];

    // Gating with reset keeps bypassed data hidden while the async clear is held.
    assign wa_act = wa_en    && !reset && !(ZERO_REG && (wa_addr    == '0));
    assign wb_act = wb_en    && !reset && !(ZERO_REG && (wb_addr    == '0));
    assign is_act = issue_en && !reset && !(ZERO_REG && (issue_addr == '0));

    always_comb begin
        busy_d = busy_q;
        if (wa_act) busy_d[wa_addr]    = 1'b0;
        if (wb_act) busy_d[wb_addr]    = 1'b0;
        if (is_act) busy_d[issue_addr] = 1'b1;

        // A clear that coincides with a same-address issue or the other write port must not count twice.
        set_bit = is_act && !busy_q[issue_addr];
        clr_a   = wa_act && busy_q[wa_addr] && !(is_act && (issue_addr == wa_addr));
        clr_b   = wb_act && busy_q[wb_addr] && !(is_act && (issue_addr == wb_addr))
                  && !(wa_act && (wa_addr == wb_addr));
        cnt_d   = cnt_q + (ADDR_W+1)'(set_bit) - (ADDR_W+1)'(clr_a) - (ADDR_W+1)'(clr_b);

        conflict_d = wa_act && wb_act && (wa_addr == wb_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            cnt_q      <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (wa_act) regs_q[wa_addr] <= wa_data;
            if (wb_act) regs_q[wb_addr] <= wb_data;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            conflict_q <= conflict_d;
        end
    end

    assign rs_addr[0] = rs0_addr;
    assign rs_addr[1] = rs1_addr;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rs_data[p] = regs_q[rs_addr[p]];
            rs_busy[p] = busy_q[rs_addr[p]];
            if (BYPASS) begin
                if (wb_act && (wb_addr == rs_addr[p])) begin
                    rs_data[p] = wb_data;
                end else if (wa_act && (wa_addr == rs_addr[p])) begin
                    rs_data[p] = wa_data;
                end
                if (((wa_act && (wa_addr == rs_addr[p])) || (wb_act && (wb_addr == rs_addr[p])))
                    && !(is_act && (issue_addr == rs_addr[p]))) begin
                    rs_busy[p] = 1'b0;
                end
            end
        end
    end

    assign rs0_data    = rs_data[0];
    assign rs1_data    = rs_data[1];
    assign rs0_busy    = rs_busy[0];
    assign rs1_busy    = rs_busy[1];
    assign dbg_data    = regs_q[dbg_addr];
    assign pending_cnt = cnt_q;
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two instances (bypass on/off) share stimulus; a reference
// model pushes per-cycle expectations that a negedge monitor pops and compares.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [4:0]  rs0_addr = '0, rs1_addr = '0, wa_addr = '0, wb_addr = '0;
    logic [4:0]  issue_addr = '0, dbg_addr = '0;
    logic        wa_en = 1'b0, wb_en = 1'b0, issue_en = 1'b0;
    logic [31:0] wa_data = '0, wb_data = '0;

    logic [31:0] b_rs0_data, b_rs1_data, b_dbg_data, n_rs0_data, n_rs1_data, n_dbg_data;
    logic        b_rs0_busy, b_rs1_busy, n_rs0_busy, n_rs1_busy;
    logic [5:0]  b_cnt, n_cnt;
    logic        b_conf, n_conf;

    regfile_scoreboard #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .rs0_addr(rs0_addr), .rs1_addr(rs1_addr),
        .rs0_data(b_rs0_data), .rs1_data(b_rs1_data),
        .rs0_busy(b_rs0_busy), .rs1_busy(b_rs1_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .dbg_addr(dbg_addr), .dbg_data(b_dbg_data),
        .pending_cnt(b_cnt), .wr_conflict(b_conf)
    );

    regfile_scoreboard #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset(reset),
        .rs0_addr(rs0_addr), .rs1_addr(rs1_addr),
        .rs0_data(n_rs0_data), .rs1_data(n_rs1_data),
        .rs0_busy(n_rs0_busy), .rs1_busy(n_rs1_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .dbg_addr(dbg_addr), .dbg_data(n_dbg_data),
        .pending_cnt(n_cnt), .wr_conflict(n_conf)
    );

    typedef struct {
        logic [31:0] rs0_b, rs0_n, rs1_b, rs1_n, dbg;
        logic        bz0_b, bz0_n, bz1_b, bz1_n;
        logic [5:0]  cnt;
        logic        conf;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state: architectural register contents and pending set.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_conf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input int a, input bit byp);
        if (reset || a == 0) return 32'h0;
        if (byp && wb_en && int'(wb_addr) == a) return wb_data;
        if (byp && wa_en && int'(wa_addr) == a) return wa_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a, input bit byp);
        bit written;
        if (reset || a == 0) return 1'b0;
        written = (wa_en && int'(wa_addr) == a) || (wb_en && int'(wb_addr) == a);
        if (byp && written && !(issue_en && int'(issue_addr) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int pending_count();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic drive(input bit rst, input bit wae, input int waa, input logic [31:0] wad,
                         input bit wbe, input int wba, input logic [31:0] wbd,
                         input bit ise, input int isa, input int r0, input int r1, input int dba);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        wa_en = wae; wa_addr = 5'(waa); wa_data = wad;
        wb_en = wbe; wb_addr = 5'(wba); wb_data = wbd;
        issue_en = ise; issue_addr = 5'(isa);
        rs0_addr = 5'(r0); rs1_addr = 5'(r1); dbg_addr = 5'(dba);

        e.rs0_b = exp_data(r0, 1'b1); e.rs0_n = exp_data(r0, 1'b0);
        e.rs1_b = exp_data(r1, 1'b1); e.rs1_n = exp_data(r1, 1'b0);
        e.bz0_b = exp_busy(r0, 1'b1); e.bz0_n = exp_busy(r0, 1'b0);
        e.bz1_b = exp_busy(r1, 1'b1); e.bz1_n = exp_busy(r1, 1'b0);
        e.dbg   = rst ? 32'h0 : m_mem[dba];
        e.cnt   = rst ? 6'd0 : 6'(pending_count());
        e.conf  = rst ? 1'b0 : m_conf;
        q.push_back(e);

        // State the model holds after the coming edge.
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
            m_conf = 1'b0;
        end else begin
            m_conf = wae && wbe && (waa == wba) && (waa != 0);
            if (wae && waa != 0) begin m_mem[waa] = wad; m_busy[waa] = 1'b0; end
            if (wbe && wba != 0) begin m_mem[wba] = wbd; m_busy[wba] = 1'b0; end
            if (ise && isa != 0) m_busy[isa] = 1'b1;
        end
    endtask

    task automatic idle(input int r0, input int r1, input int dba);
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, r0, r1, dba);
    endtask

    function automatic int pick_addr();
        if ($urandom_range(1, 0) == 1) return int'($urandom_range(7, 0));
        return int'($urandom_range(31, 0));
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk("rs0_data_byp",  b_rs0_data, e.rs0_b);
            chk("rs0_data_nob",  n_rs0_data, e.rs0_n);
            chk("rs1_data_byp",  b_rs1_data, e.rs1_b);
            chk("rs1_data_nob",  n_rs1_data, e.rs1_n);
            chk("rs0_busy_byp",  32'(b_rs0_busy), 32'(e.bz0_b));
            chk("rs0_busy_nob",  32'(n_rs0_busy), 32'(e.bz0_n));
            chk("rs1_busy_byp",  32'(b_rs1_busy), 32'(e.bz1_b));
            chk("rs1_busy_nob",  32'(n_rs1_busy), 32'(e.bz1_n));
            chk("dbg_data_byp",  b_dbg_data, e.dbg);
            chk("dbg_data_nob",  n_dbg_data, e.dbg);
            chk("pending_cnt_byp", 32'(b_cnt), 32'(e.cnt));
            chk("pending_cnt_nob", 32'(n_cnt), 32'(e.cnt));
            chk("wr_conflict_byp", 32'(b_conf), 32'(e.conf));
            chk("wr_conflict_nob", 32'(n_conf), 32'(e.conf));
        end
    end

    initial begin
        int waa, wba, isa, r0, r1;
        for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
        m_conf = 1'b0;

        drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0, 0);
        drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0, 0);
        for (int a = 0; a < 32; a++) idle(a, 31 - a, a);

        // Same-cycle bypass of a port A write, visible on dbg one cycle later.
        drive(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0, 1'b0, 0, 5, 5, 5);
        idle(5, 5, 5);

        // Port B wins a same-address collision; conflict pulses once.
        drive(1'b0, 1'b1, 7, 32'h11, 1'b1, 7, 32'h22, 1'b0, 0, 7, 7, 7);
        idle(7, 7, 7);
        idle(7, 7, 7);

        // Register 0 ignores writes and issues.
        drive(1'b0, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 32'hFFFFFFFF, 1'b1, 0, 0, 0, 0);
        idle(0, 0, 0);

        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 3, 3, 4, 3);
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 4, 3, 4, 4);
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 9, 3, 9, 9);
        drive(1'b0, 1'b1, 3, 32'hA3, 1'b1, 4, 32'hB4, 1'b1, 9, 3, 4, 9);
        idle(3, 4, 9);
        drive(1'b0, 1'b1, 9, 32'h99, 1'b0, 0, 32'h0, 1'b1, 9, 9, 9, 9);
        idle(9, 9, 9);

        for (int n = 0; n < 600; n++) begin
            waa = pick_addr(); wba = pick_addr(); isa = pick_addr();
            case ($urandom_range(2, 0))
                0: r0 = waa;
                1: r0 = wba;
                default: r0 = pick_addr();
            endcase
            r1 = ($urandom_range(1, 0) == 1) ? isa : pick_addr();
            drive(1'b0, 1'($urandom_range(1, 0)), waa, $urandom,
                  1'($urandom_range(1, 0)), wba, $urandom,
                  1'($urandom_range(1, 0)), isa, r0, r1, pick_addr());
        end

        // Mid-operation async reset with three pending registers and active writes.
        drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0, 0);
        drive(1'b0, 1'b1, 1, 32'h1, 1'b0, 0, 32'h0, 1'b1, 1, 1, 2, 1);
        drive(1'b0, 1'b1, 2, 32'h2, 1'b0, 0, 32'h0, 1'b1, 2, 1, 2, 2);
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b1, 3, 1, 3, 1);
        idle(1, 2, 2);
        drive(1'b1, 1'b1, 1, 32'h55, 1'b1, 2, 32'h66, 1'b1, 4, 1, 2, 1);
        drive(1'b1, 1'b1, 3, 32'h77, 1'b0, 0, 32'h0, 1'b0, 0, 3, 2, 2);
        idle(1, 2, 3);
        idle(3, 4, 1);

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
